// File: rtl/lane_tx_pkg.sv
// Shared types and constants for the per-lane byte serializer.
package lane_tx_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

  localparam logic [7:0] IDLE_SYM_DEFAULT = 8'hBC;
  localparam int         BYTES_PER_WORD   = 4;

endpackage

// File: rtl/lane_word_fifo.sv
// Small synchronous word FIFO with registered pointers and an occupancy count.
module lane_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [AW:0]      count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];

  // Requests are qualified here so the FIFO can never corrupt itself.
  assign doPush = push_i && !full_o;
  assign doPop  = pop_i && !empty_o;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + AW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/lane_byte_serializer.sv
// Per-lane transmit stage: buffers striper words and emits them MSB-first,
// one byte per clock, filling with IDLE_SYM when nothing is pending.
module lane_byte_serializer
  import lane_tx_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] IDLE_SYM = IDLE_SYM_DEFAULT
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [7:0]  byte_out,
  output logic        valid_out,
  output logic        k_out,
  output logic        overflow_err
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] fifoHead;
  logic        fifoFull, fifoEmpty;
  logic [AW:0] fifoCount;
  logic        pushEn, popEn;

  state_t      state_q, state_d;
  logic [31:0] sh_q, sh_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  byte_q, byte_d;
  logic        valid_q, valid_d;
  logic        k_q, k_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  curByte;

  assign ready_out = (fifoCount != (AW+1)'(DEPTH));
  assign pushEn    = valid_in && ready_out;

  lane_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (clk_4f),
    .reset_i (reset),
    .push_i  (pushEn),
    .pop_i   (popEn),
    .data_i  (data_in),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  always_comb begin
    case (idx_q)
      2'd0:    curByte = sh_q[31:24];
      2'd1:    curByte = sh_q[23:16];
      2'd2:    curByte = sh_q[15:8];
      default: curByte = sh_q[7:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    byte_d  = IDLE_SYM;
    valid_d = 1'b0;
    k_d     = 1'b1;
    popEn   = 1'b0;
    ovf_d   = ovf_q | (valid_in & fifoFull);
    case (state_q)
      ST_IDLE: begin
        if (!fifoEmpty) begin
          popEn   = 1'b1;
          sh_d    = fifoHead;
          idx_d   = 2'd0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        byte_d  = curByte;
        valid_d = 1'b1;
        k_d     = 1'b0;
        idx_d   = idx_q + 2'd1;
        // On the last byte, chain straight into the next word to avoid a gap.
        if (idx_q == 2'(BYTES_PER_WORD - 1)) begin
          idx_d = 2'd0;
          if (!fifoEmpty) begin
            popEn = 1'b1;
            sh_d  = fifoHead;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      byte_q  <= IDLE_SYM;
      valid_q <= 1'b0;
      k_q     <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      k_q     <= k_d;
      ovf_q   <= ovf_d;
    end
  end

  assign byte_out     = byte_q;
  assign valid_out    = valid_q;
  assign k_out        = k_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_lane_byte_serializer.sv
// Self-checking bench: directed and random stimulus against a queue-based
// model of pending words and pending bytes.
module tb_lane_byte_serializer;

  localparam int DEPTH = 4;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic [7:0]  byte_out;
  logic        valid_out;
  logic        k_out;
  logic        overflow_err;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [31:0] wordQ   [$];
  logic [7:0]  byteQ   [$];
  logic [31:0] acceptQ [$];
  logic [7:0]  gotBytes[$];
  int          gotCycle[$];
  logic [7:0]  expByte;
  logic        expValid;
  logic        expOvf;
  logic        sawNotReady;

  lane_byte_serializer #(
    .DEPTH    (DEPTH),
    .IDLE_SYM (8'hBC)
  ) dut (
    .clk_4f       (clk_4f),
    .reset        (reset),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .byte_out     (byte_out),
    .valid_out    (valid_out),
    .k_out        (k_out),
    .overflow_err (overflow_err)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  // One clock of the model: emit the oldest pending byte, refill from the
  // word queue once the byte queue runs dry, then accept the input word.
  task automatic modelStep(input logic rst, input logic v, input logic [31:0] d);
    bit          canAccept;
    bit          canPop;
    logic [31:0] w;
    if (rst) begin
      wordQ.delete();
      byteQ.delete();
      acceptQ.delete();
      expByte  = 8'hBC;
      expValid = 1'b0;
      expOvf   = 1'b0;
      return;
    end
    canAccept = (wordQ.size() != DEPTH);
    canPop    = (wordQ.size() > 0);
    if (byteQ.size() > 0) begin
      expByte  = byteQ.pop_front();
      expValid = 1'b1;
    end else begin
      expByte  = 8'hBC;
      expValid = 1'b0;
    end
    if (byteQ.size() == 0 && canPop) begin
      w = wordQ.pop_front();
      for (int b = 3; b >= 0; b--) byteQ.push_back(w[8*b +: 8]);
    end
    if (v) begin
      if (canAccept) begin
        wordQ.push_back(d);
        acceptQ.push_back(d);
      end else begin
        expOvf = 1'b1;
      end
    end
  endtask

  task automatic checkOutput();
    checkVal("byte_out", byte_out, expByte);
    checkVal("valid_out", valid_out, expValid);
    checkVal("k_out", k_out, !expValid);
    checkVal("ready_out", ready_out, wordQ.size() != DEPTH);
    checkVal("overflow_err", overflow_err, expOvf);
    checkVal("fifo_count", dut.fifoCount, wordQ.size());
    if (!ready_out) sawNotReady = 1'b1;
    if (valid_out) begin
      gotBytes.push_back(byte_out);
      gotCycle.push_back(cycle);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic v, input logic [31:0] d);
    @(negedge clk_4f);
    reset    = rst;
    valid_in = v;
    data_in  = d;
    @(posedge clk_4f);
    cycle++;
    modelStep(rst, v, d);
    #1;
    checkOutput();
  endtask

  task automatic clearCapture();
    gotBytes.delete();
    gotCycle.delete();
    acceptQ.delete();
  endtask

  // Compare everything emitted since the last clear against accepted words.
  task automatic compareStream(input string tag);
    logic [7:0] expList[$];
    foreach (acceptQ[i])
      for (int b = 3; b >= 0; b--) expList.push_back(acceptQ[i][8*b +: 8]);
    checkVal({tag, "_len"}, gotBytes.size(), expList.size());
    foreach (expList[i])
      if (i < gotBytes.size()) checkVal({tag, "_byte"}, gotBytes[i], expList[i]);
  endtask

  initial begin
    logic [31:0] w;
    reset       = 1'b1;
    valid_in    = 1'b0;
    data_in     = '0;
    sawNotReady = 1'b0;
    expByte     = 8'hBC;
    expValid    = 1'b0;
    expOvf      = 1'b0;

    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, '0);
      checkVal("idle_byte", byte_out, 8'hBC);
      checkVal("idle_k", k_out, 1'b1);
    end

    // Single word latency and byte order.
    clearCapture();
    applyStimulus(1'b0, 1'b1, 32'hAABBCCDD);
    applyStimulus(1'b0, 1'b0, '0);
    checkVal("lat_pop_idle", byte_out, 8'hBC);
    applyStimulus(1'b0, 1'b0, '0);
    checkVal("lat_b0", byte_out, 8'hAA);
    applyStimulus(1'b0, 1'b0, '0);
    checkVal("lat_b1", byte_out, 8'hBB);
    applyStimulus(1'b0, 1'b0, '0);
    checkVal("lat_b2", byte_out, 8'hCC);
    applyStimulus(1'b0, 1'b0, '0);
    checkVal("lat_b3", byte_out, 8'hDD);
    checkVal("lat_b3_valid", valid_out, 1'b1);
    applyStimulus(1'b0, 1'b0, '0);
    checkVal("lat_after_byte", byte_out, 8'hBC);
    checkVal("lat_after_k", k_out, 1'b1);

    // Two words two cycles apart: contiguous bytes 01..08.
    clearCapture();
    applyStimulus(1'b0, 1'b1, 32'h01020304);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 32'h05060708);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, '0);
    checkVal("b2b_count", gotBytes.size(), 8);
    for (int i = 0; i < 8 && i < gotBytes.size(); i++)
      checkVal("b2b_byte", gotBytes[i], i + 1);
    if (gotCycle.size() == 8) checkVal("b2b_contig", gotCycle[7] - gotCycle[0], 7);

    // Saturating input: ready drops, overflow sticks, stream stays in order.
    clearCapture();
    sawNotReady = 1'b0;
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 32'h10203000 + i);
    checkVal("sat_ready_low_seen", sawNotReady, 1'b1);
    checkVal("sat_overflow", overflow_err, 1'b1);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, '0);
    compareStream("sat_stream");
    checkVal("sat_overflow_sticky", overflow_err, 1'b1);

    // Reset while BB is on the output.
    applyStimulus(1'b0, 1'b1, 32'hAABBCCDD);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    checkVal("rst_pre_bb", byte_out, 8'hBB);
    applyStimulus(1'b1, 1'b0, '0);
    checkVal("rst_byte", byte_out, 8'hBC);
    checkVal("rst_k", k_out, 1'b1);
    checkVal("rst_valid", valid_out, 1'b0);
    checkVal("rst_ovf", overflow_err, 1'b0);
    checkVal("rst_count", dut.fifoCount, 0);
    clearCapture();
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, '0);
    checkVal("rst_no_leftover", gotBytes.size(), 0);

    // Simultaneous push/pop at count 2, through pointer wrap-around.
    clearCapture();
    applyStimulus(1'b0, 1'b1, 32'hC0000000);
    applyStimulus(1'b0, 1'b1, 32'hC0000001);
    applyStimulus(1'b0, 1'b1, 32'hC0000002);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    for (int n = 0; n < 2 * DEPTH + 2; n++) begin
      w = $urandom;
      applyStimulus(1'b0, 1'b1, w);
      checkVal("pp_count_hold", dut.fifoCount, 2);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0);
    end
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, '0);
    compareStream("pp_stream");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, w);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lane_byte_serializer.md
# lane_byte_serializer

Per-lane transmit stage that sits directly downstream of the two-lane word striper. It accepts 32-bit words from one lane output (lane_0 or lane_1 with its valid), buffers them in a small word FIFO, and emits them one byte per clock, MSB first. When no data is pending it fills the lane with a control IDLE symbol. One instance is placed per lane.

## Interface
Parameters:
- DEPTH, 4: word FIFO depth in words; power of two, ≥2.
- IDLE_SYM, 8'hBC: filler byte emitted when the lane has no data (COM / K28.5 code).

Ports:
- clk_4f  input  1  lane byte clock; the only clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  32  word from the striper lane output.
- valid_in  input  1  data_in is valid this cycle.
- ready_out  output  1  FIFO can accept a word this cycle.
- byte_out  output  8  serialized byte, registered.
- valid_out  output  1  byte_out carries a data byte.
- k_out  output  1  byte_out is a control symbol (IDLE_SYM).
- overflow_err  output  1  sticky flag: a word arrived while ready_out was low.

## Operation
- Push: valid_in && ready_out writes data_in at the FIFO tail.
- Drop: valid_in && !ready_out discards the word and sets overflow_err. It stays set until reset.
- ready_out = (count != DEPTH). It is combinational from the registered count and does not depend on this cycle's pop. A push into a full FIFO with a same-cycle pop is still refused.
- FSM states:
  - IDLE: emits IDLE_SYM with k_out=1 and valid_out=0.
    - If the FIFO is non-empty, pops the head into shift register sh, sets byte index idx=0, and goes to SEND.
    - The transition cycle still emits IDLE_SYM.
  - SEND: emits sh[31-8*idx -: 8] with valid_out=1 and k_out=0, then increments idx.
    - At idx==3, if the FIFO is non-empty, pops the next word into sh with idx=0 and stays in SEND (no gap byte). Otherwise it returns to IDLE.
- Byte order: bits 31:24 first, then 23:16, 15:8, 7:0.
- Counters: count is log2(DEPTH)+1 bits. Read and write pointers are log2(DEPTH) bits and wrap naturally. Simultaneous push and pop leave count unchanged.
- Sustained throughput: 1 word per 4 cycles. Faster input fills the FIFO and deasserts ready_out. The upstream block must honour ready_out.

## Timing
- Reset values: byte_out=IDLE_SYM, k_out=1, valid_out=0, overflow_err=0, ready_out=1 (count=0), FSM=IDLE, idx=0, pointers=0.
- Reset asserted mid-word flushes the FIFO and the partial word. The next cycle shows the reset values. No remaining bytes are sent.
- Latency: a word accepted at edge N into an empty FIFO with the FSM in IDLE:
  - popped at edge N+1;
  - first byte on byte_out after edge N+2;
  - last byte after edge N+5.
- Back-to-back words produce contiguous bytes with valid_out continuously high.
- The first IDLE_SYM after the last data byte appears after the edge following byte 3.
- All outputs are registered except ready_out.

## Structure
- Package lane_tx_pkg:
  - state enum {ST_IDLE, ST_SEND};
  - default IDLE_SYM constant;
  - BYTES_PER_WORD = 4.
- Sub-module lane_word_fifo: synchronous FIFO with parameter DEPTH and width 32. It has push/pop/full/empty/count and uses registered pointers.
- The top level holds the FSM, shift register, index counter, and overflow flag.

## Test plan
- Reset, then idle 10 cycles: byte_out=8'hBC, k_out=1, valid_out=0 every cycle; ready_out=1; overflow_err=0.
- Single word 32'hAABBCCDD accepted at edge N: after edges N+2..N+5, byte_out = AA, BB, CC, DD with valid_out=1 and k_out=0; then BC with k_out=1.
- Words 32'h01020304 and 32'h05060708 pushed two cycles apart: eight contiguous data bytes 01..08 with no IDLE between them.
- valid_in held high every cycle with incrementing words, DEPTH=4: ready_out drops once count reaches 4. A word presented during ready_out=0 sets overflow_err=1. The accepted words appear in order, and none is duplicated.
- Reset pulsed while byte BB of 32'hAABBCCDD is on the output: the next cycle is BC/k=1/valid=0; CC and DD are never emitted; the FIFO is empty and overflow_err is cleared.
- Push and pop in the same cycle at count=2: count stays 2, and the order is preserved across pointer wrap-around after 2*DEPTH words.
